// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and
// occupancy counter width.
package pipe_pkg;

    localparam int COUNT_W = 2;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage : pipe_pkg

// File: rtl/pipe_data_reg.sv
// LENGTH-wide data register with async reset, synchronous clear and load
// enable; clear takes priority over load.
module pipe_data_reg #(
    parameter int                 LENGTH  = 8,
    parameter logic [LENGTH-1:0]  RST_VAL = {LENGTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [LENGTH-1:0] d_i,
    output logic [LENGTH-1:0] q_o
);

    logic [LENGTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else if (clr_i) begin
            data_q <= RST_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : pipe_data_reg

// File: rtl/skid_pipe_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer, so in_ready is a pure flop with no path from out_ready.
module skid_pipe_reg
    import pipe_pkg::*;
#(
    parameter int                 LENGTH  = 8,
    parameter logic [LENGTH-1:0]  RST_VAL = {LENGTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LENGTH-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LENGTH-1:0]  out_data,
    output logic [COUNT_W-1:0] count
);

    logic [1:0]        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              inFire, outFire;
    logic              mainLoad, mainFromSkid, skidLoad;
    logic [LENGTH-1:0] mainD, skidQ;

    assign inFire  = in_valid & in_ready_q;
    assign outFire = (state_q != ST_EMPTY) & out_ready;

    // Flush wins over every handshake; FULL never sees an input fire because
    // in_ready is low there.
    always_comb begin
        state_d      = state_q;
        mainLoad     = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (inFire) begin
                        mainLoad = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (inFire && outFire) begin
                        mainLoad = 1'b1;
                    end else if (inFire) begin
                        skidLoad = 1'b1;
                        state_d  = ST_FULL;
                    end else if (outFire) begin
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (outFire) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        state_d      = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign mainD = mainFromSkid ? skidQ : in_data;

    pipe_data_reg #(
        .LENGTH  (LENGTH),
        .RST_VAL (RST_VAL)
    ) u_main_reg (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .load_i (mainLoad),
        .d_i    (mainD),
        .q_o    (out_data)
    );

    pipe_data_reg #(
        .LENGTH  (LENGTH),
        .RST_VAL (RST_VAL)
    ) u_skid_reg (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (flush),
        .load_i (skidLoad),
        .d_i    (in_data),
        .q_o    (skidQ)
    );

    always_comb begin
        count = '0;
        case (state_q)
            ST_BUSY: count = COUNT_W'(1);
            ST_FULL: count = COUNT_W'(2);
            default: count = '0;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);

endmodule : skid_pipe_reg

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg against a queue-based reference model
// of the stage's contents.
module tb_skid_pipe_reg;

    localparam int         LENGTH  = 8;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] count;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: the stage is a FIFO of at most two words.
    logic [7:0] mq[$];
    logic [7:0] mLast  = RST_VAL;
    logic       mReady = 1'b0;
    logic       mInFire, mOutFire;
    int         recvCount = 0;

    skid_pipe_reg #(
        .LENGTH  (LENGTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mq.delete();
        mLast  = RST_VAL;
        mReady = 1'b0;
    endtask

    task automatic modelEdge(input logic v, input logic [7:0] d, input logic r, input logic f);
        mInFire  = 1'b0;
        mOutFire = 1'b0;
        if (f) begin
            mq.delete();
            mLast  = RST_VAL;
            mReady = 1'b1;
        end else begin
            mOutFire = (mq.size() > 0) && r;
            mInFire  = v && mReady;
            if (mOutFire) begin
                void'(mq.pop_front());
                recvCount++;
            end
            if (mInFire) mq.push_back(d);
            if (mq.size() > 0) mLast = mq[0];
            mReady = (mq.size() < 2);
        end
    endtask

    // Drives one cycle of inputs, advances the model on the edge, samples at +1.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        modelEdge(v, d, r, f);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        checkCount++;
        if (out_data !== 8'hA5) begin failCount++; $display("[TB] FAIL reset_out_data got %h want a5", out_data); end
        checkCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checkCount++;
        if (count !== 2'd0) begin failCount++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        checkCount++;
        if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        rst = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL release_in_ready got %b want 1", in_ready); end
        checkCount++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL release_no_accept got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_stream();
        logic [7:0] words [3];
        words = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, words[i], 1'b1, 1'b0);
            checkCount++;
            if (out_data !== words[i] || out_valid !== 1'b1) begin
                failCount++; $display("[TB] FAIL stream_data[%0d] got %h/%b want %h/1", i, out_data, out_valid, words[i]);
            end
            checkCount++;
            if (count !== 2'd1 || in_ready !== 1'b1) begin
                failCount++; $display("[TB] FAIL stream_occ[%0d] got count=%0d rdy=%b want 1/1", i, count, in_ready);
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkCount++;
        if (count !== 2'd0 || out_data !== 8'h03 || out_valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL drain_hold got count=%0d data=%h valid=%b want 0/03/0", count, out_data, out_valid);
        end
    endtask

    task automatic test_stall();
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        checkCount++;
        if (count !== 2'd1 || in_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL stall_first got count=%0d rdy=%b want 1/1", count, in_ready);
        end
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        checkCount++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            failCount++; $display("[TB] FAIL stall_full got count=%0d rdy=%b want 2/0", count, in_ready);
        end
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        checkCount++;
        if (count !== 2'd2 || out_data !== 8'h10) begin
            failCount++; $display("[TB] FAIL stall_reject got count=%0d data=%h want 2/10", count, out_data);
        end
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
        checkCount++;
        if (out_data !== 8'h11 || count !== 2'd1 || in_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL unstall_1 got data=%h count=%0d rdy=%b want 11/1/1", out_data, count, in_ready);
        end
        applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
        checkCount++;
        if (out_data !== 8'h12 || count !== 2'd1) begin
            failCount++; $display("[TB] FAIL unstall_2 got data=%h count=%0d want 12/1", out_data, count);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkCount++;
        if (count !== 2'd0) begin failCount++; $display("[TB] FAIL stall_drain got count=%0d want 0", count); end
    endtask

    task automatic test_flush();
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        checkCount++;
        if (count !== 2'd2) begin failCount++; $display("[TB] FAIL flush_prefill got count=%0d want 2", count); end
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b1);
        checkCount++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'hA5) begin
            failCount++; $display("[TB] FAIL flush_state got count=%0d valid=%b data=%h want 0/0/a5", count, out_valid, out_data);
        end
        checkCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL flush_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkCount++;
            if (out_valid !== 1'b0 || out_data === 8'h22) begin
                failCount++; $display("[TB] FAIL flush_dropped[%0d] got valid=%b data=%h want 0/not 22", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkCount++;
        if (out_data !== 8'hA5 || out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset got data=%h valid=%b count=%0d rdy=%b want a5/0/0/0", out_data, out_valid, count, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkCount++;
        if (in_ready !== 1'b1 || count !== 2'd0) begin
            failCount++; $display("[TB] FAIL async_release got rdy=%b count=%0d want 1/0", in_ready, count);
        end
    endtask

    task automatic test_random();
        int  sentCount = 0;
        int  cycles    = 0;
        int  startRecv;
        logic       v, r;
        logic [7:0] d;
        startRecv = recvCount;
        while ((recvCount - startRecv) < 1000 && cycles < 20000) begin
            v = (sentCount < 1000) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            applyStimulus(v, d, r, 1'b0);
            if (mInFire) sentCount++;
            cycles++;
            checkCount++;
            if (out_valid !== (mq.size() > 0) || out_data !== mLast ||
                in_ready !== mReady || count !== 2'(mq.size())) begin
                failCount++;
                $display("[TB] FAIL random_cycle%0d got v=%b d=%h rdy=%b cnt=%0d want v=%b d=%h rdy=%b cnt=%0d",
                         cycles, out_valid, out_data, in_ready, count, mq.size() > 0, mLast, mReady, mq.size());
            end
        end
        checkCount++;
        if ((recvCount - startRecv) != 1000 || mq.size() != 0) begin
            failCount++;
            $display("[TB] FAIL random_delivery got %0d words (left %0d) want 1000 (left 0)", recvCount - startRecv, mq.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule : tb_skid_pipe_reg
